// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the one-hot traffic light bus: locks onto RED->GREEN->YELLOW->RED,
// measures dwell and flags protocol errors. Optional first-error capture via TLM_ERR_CAPTURE_EN.
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int RED_MIN    = 4,
    parameter int GREEN_MIN  = 4,
    parameter int YELLOW_MIN = 2,
    parameter int MAX_DWELL  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       light,
    input  logic             err_clr,
    output logic             locked,
    output logic [1:0]       cur_light,
    output logic [CNT_W-1:0] dwell,
    output logic [CNT_W-1:0] cycles,
`ifdef TLM_ERR_CAPTURE_EN
    output logic [2:0]       first_err_light,
    output logic [CNT_W-1:0] first_err_dwell,
`endif
    output logic             err_illegal,
    output logic             err_order,
    output logic             err_short,
    output logic             err_stall
);

    // State encoding doubles as the cur_light code so that output is a plain register.
    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_RED    = 2'b01,
        ST_GREEN  = 2'b10,
        ST_YELLOW = 2'b11
    } state_t;

    localparam logic [2:0]       CODE_RED    = 3'b100;
    localparam logic [2:0]       CODE_GREEN  = 3'b001;
    localparam logic [2:0]       CODE_YELLOW = 3'b010;
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT         = '1;

    state_t           state, state_nxt;
    state_t           sample_state;
    state_t           legal_next;
    logic             sample_valid;
    logic [CNT_W-1:0] min_dwell;
    logic [CNT_W-1:0] dwell_nxt;
    logic [CNT_W-1:0] cycles_nxt;
    logic             set_illegal, set_order, set_short, set_stall;

    always_comb begin
        sample_state = ST_UNSYNC;
        sample_valid = 1'b1;
        case (light)
            CODE_RED:    sample_state = ST_RED;
            CODE_GREEN:  sample_state = ST_GREEN;
            CODE_YELLOW: sample_state = ST_YELLOW;
            default:     sample_valid = 1'b0;
        endcase
    end

    always_comb begin
        legal_next = ST_UNSYNC;
        min_dwell  = '0;
        case (state)
            ST_RED: begin
                legal_next = ST_GREEN;
                min_dwell  = CNT_W'(RED_MIN);
            end
            ST_GREEN: begin
                legal_next = ST_YELLOW;
                min_dwell  = CNT_W'(GREEN_MIN);
            end
            ST_YELLOW: begin
                legal_next = ST_RED;
                min_dwell  = CNT_W'(YELLOW_MIN);
            end
            default: begin
                legal_next = ST_UNSYNC;
                min_dwell  = '0;
            end
        endcase
    end

    // Next-state and event decode; the first sample after UNSYNC is never dwell- or order-checked.
    always_comb begin
        state_nxt   = state;
        dwell_nxt   = dwell;
        cycles_nxt  = cycles;
        set_illegal = 1'b0;
        set_order   = 1'b0;
        set_short   = 1'b0;
        set_stall   = 1'b0;
        if (!sample_valid) begin
            set_illegal = 1'b1;
            state_nxt   = ST_UNSYNC;
            dwell_nxt   = '0;
        end else if (state == ST_UNSYNC) begin
            state_nxt = sample_state;
            dwell_nxt = ONE;
        end else if (sample_state == state) begin
            if (dwell != SAT) begin
                dwell_nxt = dwell + ONE;
            end
            if (dwell == CNT_W'(MAX_DWELL)) begin
                set_stall = 1'b1;
            end
        end else if (sample_state == legal_next) begin
            set_short = (dwell < min_dwell);
            state_nxt = sample_state;
            dwell_nxt = ONE;
            if (state == ST_YELLOW) begin
                cycles_nxt = cycles + ONE;
            end
        end else begin
            set_order = 1'b1;
            state_nxt = sample_state;
            dwell_nxt = ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_UNSYNC;
            dwell  <= '0;
            cycles <= '0;
        end else begin
            state  <= state_nxt;
            dwell  <= dwell_nxt;
            cycles <= cycles_nxt;
        end
    end

    // Sticky flags: a new event on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_illegal <= 1'b0;
            err_order   <= 1'b0;
            err_short   <= 1'b0;
            err_stall   <= 1'b0;
        end else begin
            err_illegal <= set_illegal | (err_illegal & ~err_clr);
            err_order   <= set_order   | (err_order   & ~err_clr);
            err_short   <= set_short   | (err_short   & ~err_clr);
            err_stall   <= set_stall   | (err_stall   & ~err_clr);
        end
    end

    assign cur_light = state;
    assign locked    = (state != ST_UNSYNC);

`ifdef TLM_ERR_CAPTURE_EN
    logic new_err;
    logic captured;

    assign new_err  = set_illegal | set_order | set_short | set_stall;
    // Any sticky flag set means an error has already been captured since the last clear.
    assign captured = err_illegal | err_order | err_short | err_stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            first_err_light <= '0;
            first_err_dwell <= '0;
        end else if (new_err && (!captured || err_clr)) begin
            first_err_light <= light;
            first_err_dwell <= dwell;
        end else if (err_clr) begin
            first_err_light <= '0;
            first_err_dwell <= '0;
        end
    end
`endif

endmodule
